// File: rtl/i2c_master_byte_if.sv
// Command handshake and I2C line bundle for i2c_master_byte.
// master modport is the initiator block; slave modport is the command/bus side.
interface i2c_master_byte_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_i;
    logic [7:0] wdata_i;
    logic       rack_i;
    logic       done_o;
    logic       err_o;
    logic [7:0] rdata_o;
    logic       nack_o;
    logic       busy_o;
    logic       scl_o;
    logic       sda_o;
    logic       sda_i;
    logic       scl_i;

    modport master (
        input  cmd_valid_i, cmd_i, wdata_i, rack_i, sda_i, scl_i,
        output cmd_ready_o, done_o, err_o, rdata_o, nack_o, busy_o,
        output scl_o, sda_o
    );

    modport slave (
        output cmd_valid_i, cmd_i, wdata_i, rack_i, sda_i, scl_i,
        input  cmd_ready_o, done_o, err_o, rdata_o, nack_o, busy_o,
        input  scl_o, sda_o
    );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C initiator: START/STOP/WRITE/READ in quarter-period steps.
// Define I2C_CLK_STRETCH_EN to let a responder stretch SCL-high quarters.
module i2c_master_byte #(
    parameter int CLK_DIV = 250
) (
    input logic clk_i,
    input logic rst_i,
    i2c_master_byte_if.master bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STOP, S_BIT, S_DONE
    } state_t;

    state_t state, state_nx;
    logic [1:0] q, q_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0] slot, slot_nx;
    logic [7:0] shreg, shreg_nx;
    logic [1:0] op, op_nx;
    logic rack, rack_nx;
    logic errp, errp_nx;
    logic scl, scl_nx;
    logic sda, sda_nx;
    logic done, done_nx;
    logic err, err_nx;
    logic ready, ready_nx;
    logic busy, busy_nx;
    logic [7:0] rdata, rdata_nx;
    logic nack, nack_nx;
    logic enter;
    logic bit_val;
    logic hold;

`ifdef I2C_CLK_STRETCH_EN
    // a released SCL that still reads low means the responder is stretching
    assign hold = scl && !bus.scl_i;
`else
    logic unused_scl;
    assign unused_scl = bus.scl_i;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            q     <= 2'd0;
            cnt   <= '0;
            slot  <= 4'd0;
            shreg <= 8'd0;
            op    <= 2'd0;
            rack  <= 1'b0;
            errp  <= 1'b0;
            scl   <= 1'b1;
            sda   <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            rdata <= 8'd0;
            nack  <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            cnt   <= cnt_nx;
            slot  <= slot_nx;
            shreg <= shreg_nx;
            op    <= op_nx;
            rack  <= rack_nx;
            errp  <= errp_nx;
            scl   <= scl_nx;
            sda   <= sda_nx;
            done  <= done_nx;
            err   <= err_nx;
            ready <= ready_nx;
            busy  <= busy_nx;
            rdata <= rdata_nx;
            nack  <= nack_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        cnt_nx   = cnt;
        slot_nx  = slot;
        shreg_nx = shreg;
        op_nx    = op;
        rack_nx  = rack;
        errp_nx  = errp;
        scl_nx   = scl;
        sda_nx   = sda;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        ready_nx = ready;
        busy_nx  = busy;
        rdata_nx = rdata;
        nack_nx  = nack;
        enter    = 1'b0;
        bit_val  = 1'b1;

        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid_i && ready) begin
                    ready_nx = 1'b0;
                    op_nx    = bus.cmd_i;
                    shreg_nx = bus.wdata_i;
                    rack_nx  = bus.rack_i;
                    q_nx     = 2'd0;
                    cnt_nx   = '0;
                    slot_nx  = 4'd0;
                    if (bus.cmd_i != CMD_START && !busy) begin
                        state_nx = S_DONE;
                        errp_nx  = 1'b1;
                    end else begin
                        enter = 1'b1;
                        unique case (bus.cmd_i)
                            CMD_START: state_nx = S_START;
                            CMD_STOP:  state_nx = S_STOP;
                            default:   state_nx = S_BIT;
                        endcase
                    end
                end
            end
            S_START, S_STOP, S_BIT: begin
                if (!hold) begin
                    if (cnt != CNT_MAX) begin
                        cnt_nx = cnt + CW'(1);
                    end else begin
                        cnt_nx = '0;
                        // q1->q2 boundary is mid SCL-high
                        if (state == S_BIT && q == 2'd1) begin
                            if (slot == 4'd8) begin
                                if (!op[0]) nack_nx = bus.sda_i;
                            end else if (op[0]) begin
                                shreg_nx = {shreg[6:0], bus.sda_i};
                            end
                        end
                        if (q != 2'd3) begin
                            q_nx  = q + 2'd1;
                            enter = 1'b1;
                        end else if (state == S_BIT && slot != 4'd8) begin
                            q_nx    = 2'd0;
                            slot_nx = slot + 4'd1;
                            enter   = 1'b1;
                        end else begin
                            state_nx = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_nx  = 1'b1;
                err_nx   = errp;
                errp_nx  = 1'b0;
                ready_nx = 1'b1;
                state_nx = S_IDLE;
                if (!errp) begin
                    unique case (op)
                        CMD_START: busy_nx  = 1'b1;
                        CMD_STOP:  busy_nx  = 1'b0;
                        CMD_READ:  rdata_nx = shreg;
                        default:   ;
                    endcase
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (op_nx[0])
            bit_val = (slot_nx == 4'd8) ? rack_nx : 1'b1;
        else
            bit_val = (slot_nx == 4'd8) ? 1'b1
                    : shreg_nx[3'd7 - slot_nx[2:0]];

        if (enter) begin
            unique case (state_nx)
                S_START: begin
                    unique case (q_nx)
                        2'd0:    sda_nx = 1'b1;
                        2'd1:    scl_nx = 1'b1;
                        2'd2:    sda_nx = 1'b0;
                        default: scl_nx = 1'b0;
                    endcase
                end
                S_STOP: begin
                    unique case (q_nx)
                        2'd0:    sda_nx = 1'b0;
                        2'd1:    scl_nx = 1'b1;
                        2'd2:    sda_nx = 1'b1;
                        default: ;
                    endcase
                end
                S_BIT: begin
                    unique case (q_nx)
                        2'd0: begin
                            scl_nx = 1'b0;
                            sda_nx = bit_val;
                        end
                        2'd1:    scl_nx = 1'b1;
                        2'd2:    ;
                        default: scl_nx = 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = ready;
    assign bus.done_o      = done;
    assign bus.err_o       = err;
    assign bus.rdata_o     = rdata;
    assign bus.nack_o      = nack;
    assign bus.busy_o      = busy;
    assign bus.scl_o       = scl;
    assign bus.sda_o       = sda;
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: quarter-arithmetic bus model, per-cycle compare,
// directed command sequence with literal latency/data pins.
module tb_i2c_master_byte;
    localparam int D = 4;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic resp_sda = 1'b1;
    logic stretch = 1'b0;

    always #5 clk = ~clk;

    i2c_master_byte_if bus();
    assign bus.sda_i = bus.sda_o & resp_sda;
    assign bus.scl_i = bus.scl_o & ~stretch;

    i2c_master_byte #(.CLK_DIV(D)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [1:0] mcmd;
    logic [7:0] mresp;
    logic [7:0] mw;
    logic mrack, mill, scl0, sda0, busy0;
    int L, k, lat;
    logic done_err;
    logic active = 1'b0;
    logic skip = 1'b0;
    logic idle_scl = 1'b1, idle_sda = 1'b1, idle_busy = 1'b0;
    logic [7:0] idle_rdata = 8'd0;
    logic idle_nack = 1'b0;
    logic e_scl, e_sda, e_rdy, e_done, e_busy, e_err;
    bit cap_q[$];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [8:0] cap9();
        logic [8:0] v = 9'd0;
        foreach (cap_q[i]) v = {v[7:0], cap_q[i]};
        return v;
    endfunction

    // what the SDA drive for a byte slot must be
    function automatic logic slot_drive(int s);
        if (mcmd == C_WRITE) return (s < 8) ? mw[7 - s] : 1'b1;
        return (s < 8) ? 1'b1 : mrack;
    endfunction

    function automatic void model_at(int kk);
        int qi, s, qq;
        e_done = (kk == L);
        e_rdy  = (kk >= L);
        e_err  = mill && e_done;
        e_busy = busy0;
        e_scl  = scl0;
        e_sda  = sda0;
        if (!mill) begin
            if (e_done && mcmd == C_START) e_busy = 1'b1;
            if (e_done && mcmd == C_STOP) e_busy = 1'b0;
            if (!mcmd[1]) begin
                qi = (kk / D > 3) ? 3 : kk / D;
                if (mcmd == C_START) begin
                    e_sda = (qi >= 2) ? 1'b0 : 1'b1;
                    e_scl = (qi == 0) ? scl0 : (qi <= 2);
                end else begin
                    e_sda = (qi >= 2);
                    e_scl = (qi == 0) ? scl0 : 1'b1;
                end
            end else begin
                qi = (kk / D > 35) ? 35 : kk / D;
                s  = qi / 4;
                qq = qi % 4;
                e_scl = (qq == 1 || qq == 2);
                e_sda = slot_drive(s);
            end
        end
    endfunction

    function automatic logic resp_at(int kk);
        int s;
        if (mill || !mcmd[1]) return 1'b1;
        s = (kk / D) / 4;
        if (mcmd == C_WRITE && s == 8) return mresp[0];
        if (mcmd == C_READ && s < 8) return mresp[7 - s];
        return 1'b1;
    endfunction

    always @(posedge bus.scl_o) cap_q.push_back(bus.sda_o);

    always @(negedge clk) begin
        if (rst_n && !skip) begin
            if (active) begin
                k++;
                model_at(k);
                chk("scl", bus.scl_o, e_scl);
                chk("sda", bus.sda_o, e_sda);
                chk("ready", bus.cmd_ready_o, e_rdy);
                chk("done", bus.done_o, e_done);
                chk("busy", bus.busy_o, e_busy);
                if (bus.done_o && lat < 0) begin
                    lat = k;
                    done_err = bus.err_o;
                end
                if (e_done) begin
                    chk("err", bus.err_o, e_err);
                    chk("rdata", bus.rdata_o,
                        (!mill && mcmd == C_READ) ? mresp : idle_rdata);
                    chk("nack", bus.nack_o,
                        (!mill && mcmd == C_WRITE) ? mresp[0] : idle_nack);
                end
                resp_sda = resp_at(k);
                if (k >= L) begin
                    active = 1'b0;
                    resp_sda = 1'b1;
                    idle_busy = e_busy;
                    idle_scl = e_scl;
                    idle_sda = e_sda;
                    if (!mill && mcmd == C_READ) idle_rdata = mresp;
                    if (!mill && mcmd == C_WRITE) idle_nack = mresp[0];
                end
            end else begin
                chk("idle_scl", bus.scl_o, idle_scl);
                chk("idle_sda", bus.sda_o, idle_sda);
                chk("idle_ready", bus.cmd_ready_o, 1);
                chk("idle_done", bus.done_o, 0);
                chk("idle_busy", bus.busy_o, idle_busy);
                chk("idle_rdata", bus.rdata_o, idle_rdata);
                chk("idle_nack", bus.nack_o, idle_nack);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] w,
                         input logic r, input logic [7:0] resp);
        @(negedge clk);
        mcmd = c;
        mw = w;
        mrack = r;
        mresp = resp;
        mill = (c != C_START) && !idle_busy;
        scl0 = idle_scl;
        sda0 = idle_sda;
        busy0 = idle_busy;
        L = mill ? 1 : (c[1] ? 36 * D + 1 : 4 * D + 1);
        lat = -1;
        done_err = 1'b0;
        cap_q.delete();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i = c;
        bus.wdata_i = w;
        bus.rack_i = r;
        @(posedge clk);
        k = -1;
        active = 1'b1;
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic finish_op();
        for (int i = 0; i < L + 40 && active; i++) @(posedge clk);
        if (active) begin
            checks++;
            failures++;
            $display("FAIL op_timeout cmd=%0d limit=%0d", mcmd, L + 40);
            active = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] w,
                          input logic r, input logic [7:0] resp);
        issue(c, w, r, resp);
        finish_op();
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = 2'b00;
        bus.wdata_i = 8'h00;
        bus.rack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", bus.scl_o, 1);
        chk("rst_sda", bus.sda_o, 1);
        chk("rst_ready", bus.cmd_ready_o, 1);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_nack", bus.nack_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(C_WRITE, 8'h55, 1'b0, 8'h00);
        chk("ill_wr_lat", lat, 1);
        chk("ill_wr_err", done_err, 1);
        chk("ill_wr_lines", cap_q.size(), 0);
        do_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
        chk("ill_stop_lat", lat, 1);

        do_cmd(C_START, 8'h00, 1'b0, 8'h00);
        chk("start_lat", lat, 17);
        chk("start_err", done_err, 0);
        chk("start_busy", bus.busy_o, 1);

        do_cmd(C_WRITE, 8'h88, 1'b0, 8'h00);
        chk("wr88_lat", lat, 145);
        chk("wr88_bits", cap9(), 9'h111);
        chk("wr88_nack", bus.nack_o, 0);

        do_cmd(C_WRITE, 8'h3C, 1'b0, 8'h01);
        chk("wr3c_bits", cap9(), 9'h079);
        chk("wr3c_nack", bus.nack_o, 1);

        do_cmd(C_START, 8'h00, 1'b0, 8'h00);
        chk("rstart_lat", lat, 17);

        do_cmd(C_READ, 8'h00, 1'b1, 8'hA5);
        chk("rd_a5_lat", lat, 145);
        chk("rd_a5_data", bus.rdata_o, 8'hA5);
        chk("rd_a5_sda", cap9(), 9'h1FF);

        do_cmd(C_READ, 8'h00, 1'b0, 8'h3C);
        chk("rd_3c_data", bus.rdata_o, 8'h3C);
        chk("rd_3c_sda", cap9(), 9'h1FE);

        do_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
        chk("stop_lat", lat, 17);
        chk("stop_busy", bus.busy_o, 0);
        chk("stop_lines", {bus.scl_o, bus.sda_o}, 2'b11);

        do_cmd(C_STOP, 8'h00, 1'b0, 8'h00);
        chk("stop2_lat", lat, 1);
        chk("stop2_err", done_err, 1);
        chk("stop2_lines", {bus.scl_o, bus.sda_o}, 2'b11);

        do_cmd(C_START, 8'h00, 1'b0, 8'h00);
        issue(C_WRITE, 8'hF0, 1'b0, 8'h00);
        repeat (70) @(posedge clk);
        #2 rst_n = 1'b0;
        active = 1'b0;
        #1;
        chk("mid_rst_scl", bus.scl_o, 1);
        chk("mid_rst_sda", bus.sda_o, 1);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_ready", bus.cmd_ready_o, 1);
        resp_sda = 1'b1;
        idle_scl = 1'b1;
        idle_sda = 1'b1;
        idle_busy = 1'b0;
        idle_rdata = 8'd0;
        idle_nack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_cmd(C_START, 8'h00, 1'b0, 8'h00);
        chk("restart_lat", lat, 17);

`ifdef I2C_CLK_STRETCH_EN
        @(negedge clk);
        skip = 1'b1;
        cap_q.delete();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i = C_WRITE;
        bus.wdata_i = 8'h88;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) stretch = 1'b1;
            if (c == 40) stretch = 1'b0;
            if (bus.done_o) lat = c;
        end
        chk("stretch_lat", lat, 165);
        chk("stretch_bits", cap9(), 9'h111);
        chk("stretch_nack", bus.nack_o, 1);
        idle_scl = 1'b0;
        idle_sda = 1'b1;
        idle_nack = 1'b1;
        @(posedge clk);
        skip = 1'b0;
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Synthesizable byte-level I2C master (initiator) that drives SCL and open-drain SDA toward an I2C responder on the shared bus.
- Executes one command at a time over a valid/ready interface: START (or repeated START), STOP, WRITE byte, READ byte.
- Serves as the initiator end for bus-level benches and as a reference driver for the I2CMB environment.

Parameters:
- CLK_DIV, 250, clk_i cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal range >= 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-low reset
- cmd_valid_i  input  1  command request
- cmd_ready_o  output  1  block idle and able to accept a command
- cmd_i  input  2  00=START, 01=STOP, 10=WRITE, 11=READ
- wdata_i  input  8  byte for WRITE; sampled at acceptance
- rack_i  input  1  ack bit driven after READ (0=ACK, 1=NACK); sampled at acceptance
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  valid with done_o: command illegal in current bus state
- rdata_o  output  8  byte received by last READ; held until next READ completes
- nack_o  output  1  ack bit sampled on last WRITE (1=NACK); held
- busy_o  output  1  bus owned (START issued, STOP not yet completed)
- scl_o  output  1  SCL drive (1=release)
- sda_o  output  1  SDA drive (1=release, 0=pull low)
- sda_i  input  1  resolved SDA line
- scl_i  input  1  resolved SCL line (used only with optional feature)

Behaviour:
- Reset (asynchronous, rst_i=0): scl_o=1, sda_o=1, cmd_ready_o=1, done_o=0, err_o=0, rdata_o=0, nack_o=0, busy_o=0, state=IDLE, counters=0. Reset mid-operation releases both lines immediately; any resulting bus glitch is accepted.
- Acceptance: cmd_valid_i && cmd_ready_o on a rising edge. cmd_ready_o drops the next cycle and stays low until the cycle done_o pulses. done_o and cmd_ready_o=1 appear in the same cycle.
- Error checks: WRITE or READ with busy_o=0, or STOP with busy_o=0, is illegal. The next cycle gives done_o=1 and err_o=1. No bus activity and no state change.
- Timing base: a quarter counter counts CLK_DIV cycles, then advances to the next quarter q0..q3.
- States: IDLE, START, STOP, BIT, DONE.
- START, 4 quarters:
  - q0: sda_o=1, scl_o unchanged.
  - q1: scl_o=1.
  - q2: sda_o=0.
  - q3: scl_o=0.
  - On completion, busy_o=1.
  - From IDLE this is a START; with busy_o=1 it is a repeated START. Both are legal.
- STOP, 4 quarters:
  - q0: sda_o=0.
  - q1: scl_o=1.
  - q2: sda_o=1.
  - q3: hold.
  - On completion, busy_o=0, and scl_o and sda_o end at 1.
- BIT, 9 bit slots of 4 quarters each:
  - q0: scl_o=0, set sda_o.
  - q1 and q2: scl_o=1.
  - q3: scl_o=0.
  - SDA is sampled at the q1->q2 boundary (mid SCL-high).
- WRITE: slots 1-8 drive wdata MSB first. Slot 9 releases SDA, and the sampled bit goes to nack_o.
- READ: slots 1-8 release SDA and shift the samples MSB first into rdata_o, updated at completion. Slot 9 drives sda_o=rack.
- DONE: one cycle, done_o=1, then return to IDLE.
- Latency from acceptance to done_o:
  - START and STOP: 4*CLK_DIV+1 cycles.
  - WRITE and READ: 36*CLK_DIV+1 cycles.
  - Illegal command: 1 cycle.
- SDA transitions occur only while SCL is low, except the START q2 and STOP q2 quarters.
- cmd_valid_i while cmd_ready_o=0 is ignored; the held request is accepted when ready returns.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: in every quarter where scl_o=1, the quarter counter does not advance until scl_i samples 1. A responder holding SCL low stretches the bit, and latencies grow by the stretch duration.
- Undefined: scl_i is ignored and timing is fixed as above.

Test Plan:
- CLK_DIV=4, START from reset: scl_o stays 1, sda_o falls at cycle 8 after acceptance, scl_o falls at cycle 12, done_o at cycle 17, busy_o=1, err_o=0.
- After START, WRITE 0x88 with the responder pulling SDA low in slot 9: sda_o sampled at mid-high is 1,0,0,0,1,0,0,0; done_o 145 cycles after acceptance; nack_o=0. Repeat with the responder releasing SDA: nack_o=1.
- READ with the responder driving 0xA5, rack_i=1: rdata_o=0xA5, sda_o=1 during slot 9, done_o after 145 cycles.
- STOP after the READ: sda_o rises while scl_o=1, done_o after 17 cycles, busy_o=0. A second STOP gives done_o=err_o=1 on the next cycle, and scl_o/sda_o stay 1.
- WRITE in IDLE gives err_o=1 with no line activity. Reset asserted mid-WRITE (slot 4) gives scl_o=sda_o=1, busy_o=0, cmd_ready_o=1 immediately.
- With I2C_CLK_STRETCH_EN, hold scl_i=0 for 20 cycles in slot 2 of a WRITE: done_o arrives at 165 cycles and the data bits are still correct.
